// File: rtl/collision_pkg.sv
// collision_pkg: shared state enum, BCD digit type and default constants for the collision scoreboard
package collision_pkg;
  typedef enum logic [1:0] {PLAY, FREEZE, OVER} state_t;
  typedef logic [3:0] bcd_digit_t;
  localparam int DEF_HIT_RADIUS = 10;
  localparam int DEF_LIVES_INIT = 3;
endpackage

// File: rtl/bcd_sat_counter.sv
// bcd_sat_counter: multi-digit BCD incrementer that sticks at all nines
module bcd_sat_counter
  import collision_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                ClkPort,
  input  logic                Reset,
  input  logic                clear,
  input  logic                inc,
  output logic [4*DIGITS-1:0] value
);
  logic [4*DIGITS-1:0] nxt;
  logic carry, sat;
  bcd_digit_t dig;
  always_comb begin
    nxt = value;
    carry = 1'b1;
    sat = 1'b1;
    dig = '0;
    for (int d = 0; d < DIGITS; d++) begin
      dig = value[4*d +: 4];
      sat = sat && dig == 4'd9;
      nxt[4*d +: 4] = carry ? (dig == 4'd9 ? 4'd0 : dig + 4'd1) : dig;
      carry = carry && dig == 4'd9;
    end
  end
  always_ff @(posedge ClkPort or posedge Reset)
    if (Reset) value <= '0;
    else if (clear) value <= '0;
    else if (inc && !sat) value <= nxt;
endmodule

// File: rtl/collision_scoreboard.sv
// collision_scoreboard: per-frame player/enemy overlap check feeding score, lives and
// an invulnerability/game-over FSM through a two-stage pipeline
module collision_scoreboard
  import collision_pkg::*;
#(
  parameter int N_OBJ         = 4,
  parameter int POS_W         = 10,
  parameter int HIT_RADIUS    = DEF_HIT_RADIUS,
  parameter int LIVES_INIT    = DEF_LIVES_INIT,
  parameter int FREEZE_FRAMES = 8,
  parameter int SCORE_DIGITS  = 4
) (
  input  logic                      ClkPort,
  input  logic                      Reset,
  input  logic                      clear,
  input  logic                      frame_tick,
  input  logic [POS_W-1:0]          player_x,
  input  logic [POS_W-1:0]          player_y,
  input  logic [N_OBJ*POS_W-1:0]    obj_x,
  input  logic [N_OBJ*POS_W-1:0]    obj_y,
  input  logic [N_OBJ-1:0]          obj_en,
  output logic [N_OBJ-1:0]          hit_vec,
  output logic                      hit_pulse,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [3:0]                lives,
  output logic                      invuln,
  output logic                      game_over
);
  logic [N_OBJ-1:0] ovl, prev_vec;
  logic pend, tick_ok, cnt_hit;
  logic [7:0] fcnt, fcnt_nx;
  logic [3:0] lives_nx;
  state_t state, state_nx;
  for (genvar i = 0; i < N_OBJ; i++) begin : g_ovl
    logic signed [POS_W:0] dx, dy, ax, ay;
    assign dx = $signed({1'b0, player_x}) - $signed({1'b0, obj_x[i*POS_W +: POS_W]});
    assign dy = $signed({1'b0, player_y}) - $signed({1'b0, obj_y[i*POS_W +: POS_W]});
    assign ax = dx[POS_W] ? -dx : dx;
    assign ay = dy[POS_W] ? -dy : dy;
    assign ovl[i] = obj_en[i] && ax <= $signed((POS_W+1)'(HIT_RADIUS))
                              && ay <= $signed((POS_W+1)'(HIT_RADIUS));
  end
  // a tick is only taken when stage 2 is idle, so the cycle right after a tick drops any new one
  assign tick_ok = frame_tick && !pend;
  assign cnt_hit = pend && state == PLAY && |(hit_vec & ~prev_vec);
  assign invuln = state == FREEZE;
  assign game_over = state == OVER;
  always_comb begin
    state_nx = state;
    fcnt_nx = fcnt;
    lives_nx = lives;
    case (state)
      PLAY: if (cnt_hit) begin
        lives_nx = lives - 4'd1;
        state_nx = lives == 4'd1 ? OVER : FREEZE;
        fcnt_nx = '0;
      end
      FREEZE: if (tick_ok) begin
        state_nx = fcnt == 8'(FREEZE_FRAMES - 1) ? PLAY : FREEZE;
        fcnt_nx = fcnt == 8'(FREEZE_FRAMES - 1) ? 8'd0 : fcnt + 8'd1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge ClkPort or posedge Reset)
    if (Reset) begin
      hit_vec <= '0;
      prev_vec <= '0;
      pend <= 1'b0;
      hit_pulse <= 1'b0;
      lives <= 4'(LIVES_INIT);
      state <= PLAY;
      fcnt <= '0;
    end else if (clear) begin
      hit_vec <= '0;
      prev_vec <= '0;
      pend <= 1'b0;
      hit_pulse <= 1'b0;
      lives <= 4'(LIVES_INIT);
      state <= PLAY;
      fcnt <= '0;
    end else begin
      if (tick_ok) begin
        hit_vec <= ovl;
        prev_vec <= hit_vec;
      end
      pend <= tick_ok;
      hit_pulse <= cnt_hit;
      lives <= lives_nx;
      state <= state_nx;
      fcnt <= fcnt_nx;
    end
  bcd_sat_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .ClkPort(ClkPort),
    .Reset(Reset),
    .clear(clear),
    .inc(cnt_hit),
    .value(score_bcd)
  );
endmodule

// File: tb/tb_collision_scoreboard.sv
// tb_collision_scoreboard: directed vectors and hand-built sequences for collision_scoreboard
module tb_collision_scoreboard;
  logic ClkPort = 1'b0;
  logic Reset, clear, frame_tick;
  logic [9:0] px, py;
  logic [39:0] obj_x, obj_y;
  logic [3:0] obj_en;
  logic [3:0] hit_vec, lives, hit_vec2, lives2, score2;
  logic hit_pulse, invuln, game_over, hit_pulse2, invuln2, game_over2;
  logic [15:0] score;
  int nchk = 0, nerr = 0;
  always #5 ClkPort = ~ClkPort;
  collision_scoreboard dut (
    .ClkPort(ClkPort), .Reset(Reset), .clear(clear), .frame_tick(frame_tick),
    .player_x(px), .player_y(py), .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en),
    .hit_vec(hit_vec), .hit_pulse(hit_pulse), .score_bcd(score), .lives(lives),
    .invuln(invuln), .game_over(game_over)
  );
  collision_scoreboard #(.SCORE_DIGITS(1), .FREEZE_FRAMES(1), .LIVES_INIT(15)) dut_sat (
    .ClkPort(ClkPort), .Reset(Reset), .clear(clear), .frame_tick(frame_tick),
    .player_x(px), .player_y(py), .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en),
    .hit_vec(hit_vec2), .hit_pulse(hit_pulse2), .score_bcd(score2), .lives(lives2),
    .invuln(invuln2), .game_over(game_over2)
  );
  typedef struct {
    int px, py, x0, y0, x1, y1;
    logic [3:0] en, exp;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_obj(input int ch, input int x, input int y);
    obj_x[ch*10 +: 10] = 10'(x);
    obj_y[ch*10 +: 10] = 10'(y);
  endtask
  task automatic step();
    @(negedge ClkPort);
  endtask
  task automatic tick();
    @(negedge ClkPort);
    frame_tick = 1'b1;
    @(negedge ClkPort);
    frame_tick = 1'b0;
  endtask
  task automatic do_clear();
    @(negedge ClkPort);
    clear = 1'b1;
    @(negedge ClkPort);
    clear = 1'b0;
  endtask
  task automatic hit_once();
    set_obj(0, 0, 0);
    tick();
    step();
  endtask
  task automatic away(input int n);
    set_obj(0, 200, 200);
    repeat (n) begin
      tick();
      step();
    end
  endtask
  initial begin
    Reset = 1'b1; clear = 1'b0; frame_tick = 1'b0;
    px = 10'd3; py = 10'd3; obj_en = 4'b0001;
    for (int c = 0; c < 4; c++) set_obj(c, 500, 500);
    tbl[0] = '{3, 3, 0, 0, 500, 500, 4'b0011, 4'b0001};
    tbl[1] = '{1020, 3, 5, 3, 1023, 0, 4'b0011, 4'b0010};
    tbl[2] = '{100, 100, 110, 90, 111, 100, 4'b0011, 4'b0001};
    tbl[3] = '{100, 100, 100, 111, 90, 89, 4'b0011, 4'b0000};
    tbl[4] = '{0, 0, 1023, 0, 10, 10, 4'b0011, 4'b0010};
    tbl[5] = '{50, 50, 50, 50, 55, 45, 4'b0010, 4'b0010};
    tbl[6] = '{500, 500, 0, 0, 0, 0, 4'b1111, 4'b1100};
    tbl[7] = '{500, 510, 500, 500, 489, 500, 4'b1111, 4'b1101};
    repeat (2) step();
    chk("rst_hitvec", 32'(hit_vec), 0);
    chk("rst_pulse", 32'(hit_pulse), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_invuln", 32'(invuln), 0);
    chk("rst_over", 32'(game_over), 0);
    Reset = 1'b0;
    step();
    // edge at origin, then held overlap through and beyond the freeze window
    set_obj(0, 0, 0);
    tick();
    chk("a_hitvec_t1", 32'(hit_vec), 4'b0001);
    chk("a_pulse_t1", 32'(hit_pulse), 0);
    step();
    chk("a_pulse_t2", 32'(hit_pulse), 1);
    chk("a_score", 32'(score), 16'h0001);
    chk("a_lives", 32'(lives), 2);
    chk("a_invuln", 32'(invuln), 1);
    step();
    chk("a_pulse_once", 32'(hit_pulse), 0);
    repeat (20) begin
      tick();
      step();
    end
    chk("a_held_score", 32'(score), 16'h0001);
    chk("a_held_lives", 32'(lives), 2);
    chk("a_freeze_end", 32'(invuln), 0);
    away(1);
    chk("a_away_hitvec", 32'(hit_vec), 0);
    hit_once();
    chk("a_rehit_pulse", 32'(hit_pulse), 1);
    chk("a_rehit_score", 32'(score), 16'h0002);
    chk("a_rehit_lives", 32'(lives), 1);
    // second tick right behind the first is dropped
    do_clear();
    chk("clr_lives", 32'(lives), 3);
    chk("clr_score", 32'(score), 0);
    chk("clr_invuln", 32'(invuln), 0);
    set_obj(0, 0, 0);
    @(negedge ClkPort);
    frame_tick = 1'b1;
    @(negedge ClkPort);
    set_obj(0, 200, 200);
    @(negedge ClkPort);
    frame_tick = 1'b0;
    chk("drop_hitvec", 32'(hit_vec), 4'b0001);
    chk("drop_pulse", 32'(hit_pulse), 1);
    step();
    chk("drop_hitvec_hold", 32'(hit_vec), 4'b0001);
    // clear wins over a pending stage-2 update
    do_clear();
    set_obj(0, 0, 0);
    tick();
    clear = 1'b1;
    @(negedge ClkPort);
    clear = 1'b0;
    chk("cprio_pulse", 32'(hit_pulse), 0);
    chk("cprio_score", 32'(score), 0);
    chk("cprio_lives", 32'(lives), 3);
    chk("cprio_hitvec", 32'(hit_vec), 0);
    step();
    chk("cprio_pulse_late", 32'(hit_pulse), 0);
    // several channels at once count once; a disabled channel never hits
    do_clear();
    set_obj(2, 5, 5);
    set_obj(1, 3, 3);
    obj_en = 4'b0101;
    tick();
    chk("multi_hitvec", 32'(hit_vec), 4'b0101);
    step();
    chk("multi_score", 32'(score), 16'h0001);
    chk("multi_lives", 32'(lives), 2);
    obj_en = 4'b0000;
    tick();
    chk("dis_hitvec", 32'(hit_vec), 0);
    step();
    set_obj(1, 500, 500);
    set_obj(2, 500, 500);
    obj_en = 4'b0001;
    // three spaced hits reach game over
    do_clear();
    hit_once();
    away(8);
    hit_once();
    away(8);
    hit_once();
    chk("over_lives", 32'(lives), 0);
    chk("over_flag", 32'(game_over), 1);
    chk("over_score", 32'(score), 16'h0003);
    chk("over_invuln", 32'(invuln), 0);
    away(1);
    hit_once();
    chk("over_hitvec", 32'(hit_vec), 4'b0001);
    chk("over_nopulse", 32'(hit_pulse), 0);
    chk("over_score_frz", 32'(score), 16'h0003);
    chk("over_lives_frz", 32'(lives), 0);
    do_clear();
    chk("over_clr_lives", 32'(lives), 3);
    chk("over_clr_score", 32'(score), 0);
    chk("over_clr_flag", 32'(game_over), 0);
    // Reset landing between the stages discards the pending count
    tick();
    Reset = 1'b1;
    @(negedge ClkPort);
    Reset = 1'b0;
    chk("rmid_pulse", 32'(hit_pulse), 0);
    chk("rmid_hitvec", 32'(hit_vec), 0);
    repeat (2) begin
      step();
      chk("rmid_pulse_after", 32'(hit_pulse), 0);
    end
    chk("rmid_score", 32'(score), 0);
    chk("rmid_lives", 32'(lives), 3);
    // overlap table
    do_clear();
    for (int i = 0; i < 8; i++) begin
      px = 10'(tbl[i].px);
      py = 10'(tbl[i].py);
      set_obj(0, tbl[i].x0, tbl[i].y0);
      set_obj(1, tbl[i].x1, tbl[i].y1);
      obj_en = tbl[i].en;
      tick();
      chk($sformatf("tbl%0d_hitvec", i), 32'(hit_vec), 32'(tbl[i].exp));
      step();
    end
    // single-digit score saturates at 9
    px = 10'd3; py = 10'd3; obj_en = 4'b0001;
    for (int c = 0; c < 4; c++) set_obj(c, 500, 500);
    do_clear();
    for (int i = 0; i < 12; i++) begin
      away(1);
      hit_once();
      if (i == 8) chk("sat_score_9", 32'(score2), 9);
    end
    chk("sat_score_hold", 32'(score2), 9);
    chk("sat_lives", 32'(lives2), 3);
    chk("sat_not_over", 32'(game_over2), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
